// File: rtl/magnitude_squared_cal.sv
// magnitude_squared_cal: computes re^2 + im^2 of one signed complex sample with a serial shift-add multiplier.
// Ports: clock/reset (sync, active-high); enable starts a computation when idle, capturing realIn/imagIn;
// busy is high while computing; valid pulses one cycle when outputData holds a new unsigned result.
module magnitude_squared_cal #(
  parameter int INPUT_DATA_WIDTH  = 42,
  parameter int OUTPUT_DATA_WIDTH = 84,
  parameter int COUNT_WIDTH       = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [INPUT_DATA_WIDTH-1:0]  realIn,
  input  logic [INPUT_DATA_WIDTH-1:0]  imagIn,
  output logic                         busy,
  output logic                         valid,
  output logic [OUTPUT_DATA_WIDTH-1:0] outputData
);
  typedef enum logic [1:0] {IDLE, MULT, SUM} state_t;
  state_t state, state_next;
  logic [INPUT_DATA_WIDTH-1:0] mag_re, mag_im, abs_re, abs_im;
  logic [OUTPUT_DATA_WIDTH-1:0] acc_re, acc_im, pp_re, pp_im;
  logic [COUNT_WIDTH-1:0] counter;
  logic last;
  // The most-negative input negates to 2^(W-1), which is exact as a W-bit unsigned value.
  assign abs_re = realIn[INPUT_DATA_WIDTH-1] ? -realIn : realIn;
  assign abs_im = imagIn[INPUT_DATA_WIDTH-1] ? -imagIn : imagIn;
  assign last = counter == COUNT_WIDTH'(INPUT_DATA_WIDTH - 1);
  // Each magnitude is squared by multiplying it with itself, one multiplier bit per clock.
  assign pp_re = mag_re[counter] ? ({{(OUTPUT_DATA_WIDTH-INPUT_DATA_WIDTH){1'b0}}, mag_re} << counter) : '0;
  assign pp_im = mag_im[counter] ? ({{(OUTPUT_DATA_WIDTH-INPUT_DATA_WIDTH){1'b0}}, mag_im} << counter) : '0;
  always_comb begin
    state_next = state;
    state_next = (state == IDLE) ? (enable ? MULT : IDLE) :
                 (state == MULT) ? (last ? SUM : MULT) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      busy       <= 1'b0;
      valid      <= 1'b0;
      outputData <= '0;
      mag_re     <= '0;
      mag_im     <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
      counter    <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          mag_re  <= abs_re;
          mag_im  <= abs_im;
          acc_re  <= '0;
          acc_im  <= '0;
          counter <= '0;
          busy    <= 1'b1;
        end
        MULT: begin
          acc_re  <= acc_re + pp_re;
          acc_im  <= acc_im + pp_im;
          counter <= counter + 1'b1;
        end
        SUM: begin
          outputData <= acc_re + acc_im;
          valid      <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_magnitude_squared_cal.sv
// tb_magnitude_squared_cal: directed self-checking bench for magnitude_squared_cal.
module tb_magnitude_squared_cal;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [41:0] realIn = '0;
  logic [41:0] imagIn = '0;
  logic busy, valid;
  logic [83:0] outputData;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k = 0;
  magnitude_squared_cal dut (
    .clock(clock), .reset(reset), .enable(enable), .realIn(realIn), .imagIn(imagIn),
    .busy(busy), .valid(valid), .outputData(outputData)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Drive one accepting edge; returns at the following negedge with k = accept edge index.
  task automatic issue(input logic [41:0] re, input logic [41:0] im);
    @(negedge clock);
    realIn = re;
    imagIn = im;
    enable = 1'b1;
    @(negedge clock);
    k = cyc;
    enable = 1'b0;
    realIn = 42'h155_5555_5555;
    imagIn = 42'h2AA_AAAA_AAAA;
  endtask
  // Waits for the result edge k+43, checking busy/valid beforehand and the pulse width after.
  task automatic finish(input string tag, input logic [83:0] exp);
    int bad = 0;
    while (cyc < k + 43) begin
      if (busy !== 1'b1 || valid !== 1'b0) bad++;
      @(negedge clock);
    end
    check({tag, "_busy_window"}, 84'(bad), 84'd0);
    check({tag, "_valid"}, 84'(valid), 84'd1);
    check({tag, "_busy_done"}, 84'(busy), 84'd0);
    check({tag, "_data"}, outputData, exp);
    @(negedge clock);
    check({tag, "_valid_drop"}, 84'(valid), 84'd0);
  endtask
  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clock);
      if (valid !== 1'b0) seen++;
    end
    check(tag, 84'(seen), 84'd0);
  endtask
  initial begin
    int t1, t2, n;
    repeat (2) @(negedge clock);
    check("rst_busy", 84'(busy), 84'd0);
    check("rst_valid", 84'(valid), 84'd0);
    check("rst_data", outputData, 84'd0);
    reset = 1'b0;
    issue(42'd3, 42'(-4));
    finish("p3m4", 84'd25);
    issue(42'h200_0000_0000, 42'h200_0000_0000);
    finish("minneg", 84'd1 << 83);
    issue(42'h1FF_FFFF_FFFF, 42'd0);
    finish("maxpos", (84'd1 << 82) - (84'd1 << 42) + 84'd1);
    issue(42'd0, 42'd0);
    finish("zero", 84'd0);
    issue(42'd1, 42'(-1));
    finish("p1m1", 84'd2);
    issue(42'd5, 42'd12);
    repeat (10) @(negedge clock);
    realIn = 42'd100;
    imagIn = 42'd100;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    finish("busy_ignore", 84'd169);
    quiet("no_queued", 60);
    issue(42'd7, 42'd7);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", 84'(busy), 84'd0);
    check("midrst_valid", 84'(valid), 84'd0);
    check("midrst_data", outputData, 84'd0);
    quiet("midrst_quiet", 60);
    issue(42'd6, 42'd8);
    finish("p6p8", 84'd100);
    @(negedge clock);
    realIn = 42'd1;
    imagIn = 42'd2;
    enable = 1'b1;
    @(negedge clock);
    realIn = 42'd3;
    imagIn = 42'd3;
    t1 = -1;
    t2 = -1;
    n = 0;
    while (t2 < 0 && n < 120) begin
      if (valid === 1'b1) begin
        if (t1 < 0) begin
          t1 = cyc;
          check("cont_first", outputData, 84'd5);
        end else begin
          t2 = cyc;
          check("cont_second", outputData, 84'd18);
        end
      end
      @(negedge clock);
      n++;
    end
    enable = 1'b0;
    check("cont_found", 84'(t1 >= 0 && t2 >= 0), 84'd1);
    check("cont_spacing", 84'(t2 - t1), 84'd44);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/magnitude_squared_cal.md
Name: magnitude_squared_cal

Overview:
- Computes the squared magnitude re² + im² of one signed complex sample (e.g. an FFT bin).
- Sits directly upstream of the square-root stage:
  - outputData drives that stage's inputData.
  - valid drives that stage's enable.
- Uses an iterative shift-add multiplier (one multiplier bit per clock) to avoid wide hardware multipliers.
- Accepts a new sample only when idle.

Parameters:
- INPUT_DATA_WIDTH, 42, width of the signed two's-complement real and imaginary inputs.
- OUTPUT_DATA_WIDTH, 84, unsigned result width; must equal 2*INPUT_DATA_WIDTH.
- COUNT_WIDTH, 6, bit-counter width; must satisfy 2^COUNT_WIDTH > INPUT_DATA_WIDTH.

Ports:
- clock  input  1  single design clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  start strobe; sampled only in IDLE.
- realIn  input  INPUT_DATA_WIDTH  signed real part; captured on the accepting edge.
- imagIn  input  INPUT_DATA_WIDTH  signed imaginary part; captured on the accepting edge.
- busy  output  1  high while a computation is in progress.
- valid  output  1  one-cycle pulse; outputData holds a new result.
- outputData  output  OUTPUT_DATA_WIDTH  unsigned re² + im².

Behaviour:
- Reset (reset high at a rising edge):
  - state←IDLE; busy, valid, outputData, counter and accumulators all ←0.
  - Reset overrides every other condition, including mid-computation; the partial result is discarded and no valid is issued.
- States: IDLE → MULT → SUM → IDLE.
- IDLE:
  - On an edge with enable=1: capture |realIn| and |imagIn| as INPUT_DATA_WIDTH-bit unsigned magnitudes (two's-complement negate when MSB=1).
  - The most-negative input −2^(W−1) maps to magnitude 2^(W−1), which fits W unsigned bits; no saturation.
  - Also on that edge: clear both OUTPUT_DATA_WIDTH accumulators, counter←0, busy←1, state←MULT.
  - enable=0: remain in IDLE.
- MULT:
  - Each edge processes multiplier bit [counter] of each magnitude in parallel: accX += (magX[counter] ? magX << counter : 0), for X = re and im.
  - counter increments each edge.
  - After exactly INPUT_DATA_WIDTH MULT edges (counter reaches W−1 and is processed): state←SUM.
- SUM (one edge):
  - outputData ← accRe + accIm. No overflow is possible: max 2·2^(2W−2) = 2^(2W−1) fits 2W bits.
  - On the same edge: valid←1, busy←0, state←IDLE.
- valid:
  - High for exactly one cycle, in the cycle after the SUM edge.
  - Deasserted on the next edge unless a new result completes (impossible within one cycle).
- Latency: the edge that accepts enable is edge k. valid is visible in the cycle after edge k+W+1 (W=42 → edge k+43).
- busy: visible high from after edge k through the cycle preceding valid.
- enable while busy: ignored; it is not queued and has no effect on the in-flight result.
- Back-to-back operation:
  - enable may be high in the same cycle valid is high. It is accepted (state is IDLE).
  - Minimum issue interval is W+2 cycles.
- outputData:
  - Holds its last result between computations; it is not cleared when idle.
  - The downstream stage qualifies it with valid.
- realIn/imagIn: need only be stable at the accepting edge.

Test Plan:
- realIn=3, imagIn=−4, enable pulsed one cycle → valid one cycle exactly 43 edges later, outputData=25; busy high for the 42 intervening cycles.
- realIn=imagIn=−2^41 → outputData=2^83 (bit 83 set, all others 0); same with realIn=2^41−1, imagIn=0 → outputData=(2^41−1)².
- realIn=imagIn=0 → valid pulses on schedule, outputData=0; then realIn=1, imagIn=−1 → outputData=2.
- Start (5, 12); pulse enable with (100, 100) at cycle 10 of MULT → the first result is 169 on schedule; no second valid follows without a new enable.
- Start (7, 7); assert reset at MULT cycle 20 → next cycle busy=0, valid=0, outputData=0; no valid pulse appears afterwards; a subsequent (6, 8) yields 100.
- Hold enable high continuously with (1, 2) then (3, 3) → results 5 and 18; valid pulses exactly 44 cycles apart.
